// File: rtl/dglk_spi_slave_regfile.sv
// -----------------------------------------------------------------------------
// dglk_spi_slave_regfile
//   SPI responder holding a small register file. The SPI pins are oversampled
//   in the clk domain: csb, sclk and mosi each pass through a 2-FF
//   synchronizer, and sclk edges are found against a 1-cycle-delayed copy.
//   A frame is R/W bit + ADR_W address bits + DAT_W data bits, MSB first.
//   Writes land in the register file and pulse wr_stb. Reads shift the
//   addressed register out on miso. Out-of-range addresses pulse err_stb.
//
// Ports
//   clk      in   system clock, at least 8x the sclk frequency
//   rst      in   asynchronous active-high reset
//   csb      in   chip select, active low, asynchronous to clk
//   sclk     in   SPI clock, asynchronous to clk
//   mosi     in   serial data in, MSB first
//   miso     out  serial data out, MSB first (registered)
//   miso_oe  out  high while the synchronized csb is low
//   wr_stb   out  1-cycle pulse per completed in-range write
//   wr_adr   out  address of the last write (held)
//   wr_dat   out  data of the last write (held)
//   err_stb  out  1-cycle pulse per completed frame with address >= N_REG
//   reg_q    out  flattened register file, reg i at [i*DAT_W +: DAT_W]
//
// Handshake: there is no valid/ready pair. wr_stb and err_stb are single
// cycle qualifiers; wr_adr/wr_dat are valid in the cycle wr_stb is high and
// hold until the next in-range write.
// -----------------------------------------------------------------------------
module dglk_spi_slave_regfile #(
    parameter int               SPI_CPOL = 0,
    parameter int               SPI_CPHA = 0,
    parameter int               ADR_W    = 4,
    parameter int               DAT_W    = 16,
    parameter int               N_REG    = 12,
    parameter logic [DAT_W-1:0] REG_INIT = '0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   csb,
    input  logic                   sclk,
    input  logic                   mosi,
    output logic                   miso,
    output logic                   miso_oe,
    output logic                   wr_stb,
    output logic [ADR_W-1:0]       wr_adr,
    output logic [DAT_W-1:0]       wr_dat,
    output logic                   err_stb,
    output logic [N_REG*DAT_W-1:0] reg_q
);

    localparam int FRM   = 1 + ADR_W + DAT_W;
    localparam int CNT_W = $clog2(FRM + 1);
    localparam logic [CNT_W-1:0] LAST_ADR  = CNT_W'(ADR_W);
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRM - 1);
    localparam logic [ADR_W:0]   N_REG_L   = (ADR_W + 1)'(N_REG);
    localparam logic             SCLK_IDLE = logic'(SPI_CPOL != 0);
    // Modes 1 and 2 sample on the falling edge, modes 0 and 3 on the rising.
    localparam logic             SAMPLE_FALL = logic'(SPI_CPOL != SPI_CPHA);

    typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA, ST_DONE} state_t;

    // Synchronizers
    logic r_csb_s1, r_csb_s2, r_csb_d;
    logic r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic r_mosi_s1, r_mosi_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_csb_s1  <= 1'b1;
            r_csb_s2  <= 1'b1;
            r_csb_d   <= 1'b1;
            r_sclk_s1 <= SCLK_IDLE;
            r_sclk_s2 <= SCLK_IDLE;
            r_sclk_d  <= SCLK_IDLE;
            r_mosi_s1 <= 1'b0;
            r_mosi_s2 <= 1'b0;
        end else begin
            r_csb_s1  <= csb;
            r_csb_s2  <= r_csb_s1;
            r_csb_d   <= r_csb_s2;
            r_sclk_s1 <= sclk;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_mosi_s1 <= mosi;
            r_mosi_s2 <= r_mosi_s1;
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_sample, w_shift, w_csb_fall;
    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_sample    = ~r_csb_s2 & (SAMPLE_FALL ? w_sclk_fall : w_sclk_rise);
    assign w_shift     = ~r_csb_s2 & (SAMPLE_FALL ? w_sclk_rise : w_sclk_fall);
    assign w_csb_fall  = r_csb_d & ~r_csb_s2;

    // Frame state
    state_t              r_state;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [ADR_W:0]      r_hdr;   // {rw, adr} once the address phase is over
    logic [DAT_W-2:0]    r_dat;   // data bits received so far
    logic [DAT_W-1:0]    r_tx;    // read shift register
    logic                r_miso;
    logic                r_wr_stb, r_err_stb;
    logic [ADR_W-1:0]    r_wr_adr;
    logic [DAT_W-1:0]    r_wr_dat;
    logic [DAT_W-1:0]    r_regs [N_REG];

    // Values including the bit being sampled this cycle.
    logic [ADR_W:0] w_hdr_next;
    logic [DAT_W-1:0] w_dat_next;
    logic w_hdr_in_range, w_adr_in_range;
    assign w_hdr_next     = {r_hdr[ADR_W-1:0], r_mosi_s2};
    assign w_dat_next     = {r_dat, r_mosi_s2};
    assign w_hdr_in_range = {1'b0, w_hdr_next[ADR_W-1:0]} < N_REG_L;
    assign w_adr_in_range = {1'b0, r_hdr[ADR_W-1:0]} < N_REG_L;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // DONE at reset: a csb held low across reset must go high first.
            r_state   <= ST_DONE;
            r_bit_cnt <= '0;
            r_hdr     <= '0;
            r_dat     <= '0;
            r_tx      <= '0;
            r_miso    <= 1'b0;
            r_wr_stb  <= 1'b0;
            r_err_stb <= 1'b0;
            r_wr_adr  <= '0;
            r_wr_dat  <= '0;
            for (int i = 0; i < N_REG; i++) r_regs[i] <= REG_INIT;
        end else begin
            r_wr_stb  <= 1'b0;
            r_err_stb <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_miso <= 1'b0;
                    if (w_csb_fall) begin
                        r_state   <= ST_ADDR;
                        r_bit_cnt <= '0;
                    end
                end
                ST_ADDR: begin
                    if (r_csb_s2) begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end else if (w_sample) begin
                        r_hdr     <= w_hdr_next;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == LAST_ADR) begin
                            r_state <= ST_DATA;
                            r_tx    <= (w_hdr_next[ADR_W] && w_hdr_in_range) ?
                                       r_regs[w_hdr_next[ADR_W-1:0]] : '0;
                        end
                    end
                end
                ST_DATA: begin
                    // csb wins over a simultaneous final sample edge.
                    if (r_csb_s2) begin
                        r_state <= ST_IDLE;
                        r_miso  <= 1'b0;
                    end else begin
                        if (w_shift && r_hdr[ADR_W]) begin
                            r_miso <= r_tx[DAT_W-1];
                            r_tx   <= {r_tx[DAT_W-2:0], 1'b0};
                        end
                        if (w_sample) begin
                            r_dat     <= w_dat_next[DAT_W-2:0];
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                            if (r_bit_cnt == LAST_BIT) begin
                                r_state <= ST_DONE;
                                r_miso  <= 1'b0;
                                if (!w_adr_in_range) begin
                                    r_err_stb <= 1'b1;
                                end else if (!r_hdr[ADR_W]) begin
                                    r_regs[r_hdr[ADR_W-1:0]] <= w_dat_next;
                                    r_wr_adr <= r_hdr[ADR_W-1:0];
                                    r_wr_dat <= w_dat_next;
                                    r_wr_stb <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_miso <= 1'b0;
                    if (r_csb_s2) r_state <= ST_IDLE;
                end
                default: r_state <= ST_DONE;
            endcase
        end
    end

    assign miso    = r_miso;
    assign miso_oe = ~r_csb_s2;
    assign wr_stb  = r_wr_stb;
    assign err_stb = r_err_stb;
    assign wr_adr  = r_wr_adr;
    assign wr_dat  = r_wr_dat;

    for (genvar gi = 0; gi < N_REG; gi++) begin : g_flat
        assign reg_q[gi*DAT_W +: DAT_W] = r_regs[gi];
    end

endmodule

// File: tb/tb_dglk_spi_slave_regfile.sv
module tb_dglk_spi_slave_regfile;

  localparam int ADR_W = 4;
  localparam int DAT_W = 16;
  localparam int N_REG = 12;
  localparam int FRM   = 1 + ADR_W + DAT_W;
  localparam int NM    = 4;                 // one DUT per CPOL/CPHA mode
  localparam int EV_W  = 2 + 2 + ADR_W + DAT_W;
  localparam int RW    = N_REG * DAT_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NM-1:0] tb_csb, tb_sclk, tb_mosi;
  logic [NM-1:0] w_miso, w_miso_oe, w_wr_stb, w_err_stb;
  logic [ADR_W-1:0] w_wr_adr [NM];
  logic [DAT_W-1:0] w_wr_dat [NM];
  logic [RW-1:0]    w_reg_q  [NM];

  for (genvar g = 0; g < NM; g++) begin : g_dut
    dglk_spi_slave_regfile #(
      .SPI_CPOL(g / 2), .SPI_CPHA(g % 2),
      .ADR_W(ADR_W), .DAT_W(DAT_W), .N_REG(N_REG), .REG_INIT('0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .csb(tb_csb[g]), .sclk(tb_sclk[g]), .mosi(tb_mosi[g]),
      .miso(w_miso[g]), .miso_oe(w_miso_oe[g]),
      .wr_stb(w_wr_stb[g]), .wr_adr(w_wr_adr[g]), .wr_dat(w_wr_dat[g]),
      .err_stb(w_err_stb[g]), .reg_q(w_reg_q[g])
    );
  end

  // ---------------- scoreboard ----------------
  // event word: {kind(1=write,2=error), mode, adr, dat}
  logic [EV_W-1:0] ev_exp_q[$];
  logic [FRM-1:0]  rx_exp_q[$];
  logic [FRM-1:0]  rx_obs_q[$];
  logic [DAT_W-1:0] model [NM][16];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic ev_check(input logic [EV_W-1:0] obs, input string name);
    logic [EV_W-1:0] e;
    checks++;
    if (ev_exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected act=%0h exp=none", name, obs);
    end else begin
      e = ev_exp_q.pop_front();
      if (obs !== e) begin
        failures++;
        $display("FAIL %s act=%0h exp=%0h", name, obs, e);
      end
    end
  endtask

  // Monitor: pops expectations whenever a DUT presents a strobe or a frame's
  // miso word has been collected.
  always @(negedge clk) begin
    for (int m = 0; m < NM; m++) begin
      if (w_wr_stb[m] === 1'b1)
        ev_check({2'd1, 2'(m), w_wr_adr[m], w_wr_dat[m]}, "wr_stb");
      if (w_err_stb[m] === 1'b1)
        ev_check({2'd2, 2'(m), {ADR_W{1'b0}}, {DAT_W{1'b0}}}, "err_stb");
    end
    if (rx_obs_q.size() > 0) begin
      logic [FRM-1:0] o, e;
      o = rx_obs_q.pop_front();
      checks++;
      if (rx_exp_q.size() == 0) begin
        failures++;
        $display("FAIL miso_word unexpected act=%0h exp=none", o);
      end else begin
        e = rx_exp_q.pop_front();
        if (o !== e) begin
          failures++;
          $display("FAIL miso_word act=%0h exp=%0h", o, e);
        end
      end
    end
  end

  function automatic logic [RW-1:0] exp_regs(input int m);
    logic [RW-1:0] r;
    r = '0;
    for (int i = 0; i < N_REG; i++) r[i*DAT_W +: DAT_W] = model[m][i];
    return r;
  endfunction

  // ---------------- driver ----------------
  // Drives one frame as an SPI master of mode m. Pins change on negedge clk.
  // n_bits < FRM aborts early; rst_at >= 0 pulses rst before that bit.
  task automatic spi_frame(input int m, input logic [FRM-1:0] word, input int n_bits,
                           input int rst_at, input bit jit, output logic [FRM-1:0] rx);
    int half;
    bit cpha;
    cpha = (m % 2) == 1;
    rx = '0;
    @(negedge clk);
    tb_csb[m] = 1'b0;
    repeat (4) @(negedge clk);
    check("miso_oe_active", RW'(w_miso_oe[m]), RW'(1));
    for (int i = 0; i < n_bits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      half = jit ? 3 + int'($urandom_range(0, 2)) : 4;
      if (!cpha) begin
        tb_mosi[m] = word[FRM-1-i];
        repeat (half) @(negedge clk);
        rx = {rx[FRM-2:0], w_miso[m]};
        tb_sclk[m] = ~tb_sclk[m];
        repeat (half) @(negedge clk);
        tb_sclk[m] = ~tb_sclk[m];
      end else begin
        tb_sclk[m] = ~tb_sclk[m];
        tb_mosi[m] = word[FRM-1-i];
        repeat (half) @(negedge clk);
        rx = {rx[FRM-2:0], w_miso[m]};
        tb_sclk[m] = ~tb_sclk[m];
        repeat (half) @(negedge clk);
      end
    end
    repeat (4) @(negedge clk);
    tb_csb[m] = 1'b1;
    repeat (8) @(negedge clk);
    check("miso_oe_idle", RW'(w_miso_oe[m]), RW'(0));
    check("miso_idle", RW'(w_miso[m]), RW'(0));
  endtask

  task automatic do_write(input int m, input logic [ADR_W-1:0] adr,
                          input logic [DAT_W-1:0] dat, input bit jit);
    logic [FRM-1:0] rx;
    rx_exp_q.push_back('0);
    if (int'(adr) < N_REG) begin
      model[m][adr] = dat;
      ev_exp_q.push_back({2'd1, 2'(m), adr, dat});
    end else begin
      ev_exp_q.push_back({2'd2, 2'(m), {ADR_W{1'b0}}, {DAT_W{1'b0}}});
    end
    spi_frame(m, {1'b0, adr, dat}, FRM, -1, jit, rx);
    rx_obs_q.push_back(rx);
  endtask

  task automatic do_read(input int m, input logic [ADR_W-1:0] adr, input bit jit);
    logic [FRM-1:0] rx;
    logic [DAT_W-1:0] filler;
    filler = DAT_W'($urandom());
    if (int'(adr) < N_REG) begin
      rx_exp_q.push_back({{(1 + ADR_W){1'b0}}, model[m][adr]});
    end else begin
      rx_exp_q.push_back('0);
      ev_exp_q.push_back({2'd2, 2'(m), {ADR_W{1'b0}}, {DAT_W{1'b0}}});
    end
    spi_frame(m, {1'b1, adr, filler}, FRM, -1, jit, rx);
    rx_obs_q.push_back(rx);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((ev_exp_q.size() != 0 || rx_obs_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, RW'(ev_exp_q.size() + rx_obs_q.size()), RW'(0));
  endtask

  task automatic check_all_regs(input string name);
    for (int m = 0; m < NM; m++) check(name, w_reg_q[m], exp_regs(m));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [FRM-1:0] rx;
    logic [ADR_W-1:0] adrs [8];
    tb_csb  = '1;
    tb_sclk = 4'b1100;
    tb_mosi = '0;
    rst = 1'b1;
    for (int m = 0; m < NM; m++)
      for (int a = 0; a < 16; a++) model[m][a] = '0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    for (int m = 0; m < NM; m++) begin
      check("rst_reg_q", w_reg_q[m], '0);
      check("rst_wr_adr", RW'(w_wr_adr[m]), '0);
      check("rst_wr_dat", RW'(w_wr_dat[m]), '0);
      check("rst_miso", RW'(w_miso[m]), '0);
      check("rst_miso_oe", RW'(w_miso_oe[m]), '0);
      check("rst_wr_stb", RW'(w_wr_stb[m]), '0);
      check("rst_err_stb", RW'(w_err_stb[m]), '0);
    end

    // write then read back, mode 0
    do_write(0, 4'h3, 16'hBEEF, 1'b0);
    wait_drain("drain_write");
    check_all_regs("regs_after_write");
    do_read(0, 4'h3, 1'b0);
    wait_drain("drain_read");

    // abort after 10 data bits, then a full frame to the same address
    spi_frame(0, {1'b0, 4'h5, 16'h1234}, 1 + ADR_W + 10, -1, 1'b0, rx);
    wait_drain("drain_abort");
    check_all_regs("regs_after_abort");
    do_write(0, 4'h5, 16'h5A5A, 1'b0);
    do_read(0, 4'h5, 1'b0);
    wait_drain("drain_after_abort");

    // out-of-range write and read
    do_write(0, 4'hE, 16'hCAFE, 1'b0);
    do_read(0, 4'hE, 1'b0);
    do_read(0, 4'hB, 1'b0);
    wait_drain("drain_oor");
    check_all_regs("regs_after_oor");

    // random writes then reads in every mode, odd frames with jitter
    for (int m = 0; m < NM; m++) begin
      for (int i = 0; i < 8; i++) begin
        adrs[i] = ADR_W'($urandom_range(0, 15));
        do_write(m, adrs[i], DAT_W'($urandom()), (i % 2) == 1);
      end
      for (int i = 0; i < 8; i++) do_read(m, adrs[i], (i % 2) == 0);
      wait_drain("drain_random");
      check_all_regs("regs_random");
    end

    // reset during the address phase with csb held low
    spi_frame(0, {1'b0, 4'h2, 16'hABCD}, FRM, 3, 1'b0, rx);
    for (int m = 0; m < NM; m++)
      for (int a = 0; a < 16; a++) model[m][a] = '0;
    wait_drain("drain_rst");
    check_all_regs("regs_after_rst");
    check("rst_mid_wr_adr", RW'(w_wr_adr[0]), '0);
    check("rst_mid_wr_dat", RW'(w_wr_dat[0]), '0);
    do_write(0, 4'h2, 16'h0F0F, 1'b0);
    do_read(0, 4'h2, 1'b0);
    do_write(3, 4'h7, 16'h8001, 1'b1);
    do_read(3, 4'h7, 1'b1);
    wait_drain("drain_final");
    check_all_regs("regs_final");
    check("exp_q_leftover", RW'(rx_exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout act=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
